// File: rtl/prime_scan_engine.sv
// ---------------------------------------------------------------------------
// prime_scan_engine
//
// Purpose:
//   Sequential trial-division prime scanner. A start request in IDLE captures
//   num_max. Every candidate from 2 to num_max is then tested, with one
//   divisor tried per clock. Each prime found is streamed out with a one-cycle
//   prime_valid pulse, and a running (saturating) prime count is kept.
//
// Optional build macro:
//   PRIME_SCAN_ODD_SKIP_EN - when defined, the only even candidate tested is 2.
//   Divisors start at 3 and step by 2. The prime stream and the final count
//   are the same as in the default build; only the cycle counts differ.
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   synchronous, active-low reset
//   start            in   scan request, sampled only in IDLE
//   num_max          in   [WIDTH]   inclusive upper bound, captured on start
//   busy             out  high while a scan is in progress
//   done             out  one-cycle pulse when a scan completes
//   prime_valid      out  one-cycle pulse, prime_out holds a new prime
//   prime_out        out  [WIDTH]   last prime found
//   number_checked   out  [WIDTH]   last candidate that received a verdict
//   number_of_primes out  [COUNT_W] primes found in the current scan
// ---------------------------------------------------------------------------
module prime_scan_engine #(
  parameter int WIDTH   = 11,
  parameter int COUNT_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   num_max,
  output logic               busy,
  output logic               done,
  output logic               prime_valid,
  output logic [WIDTH-1:0]   prime_out,
  output logic [WIDTH-1:0]   number_checked,
  output logic [COUNT_W-1:0] number_of_primes
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef PRIME_SCAN_ODD_SKIP_EN
  localparam logic [WIDTH-1:0] D_INIT = WIDTH'(3);
  localparam logic [WIDTH-1:0] D_STEP = WIDTH'(2);
`else
  localparam logic [WIDTH-1:0] D_INIT = WIDTH'(2);
  localparam logic [WIDTH-1:0] D_STEP = WIDTH'(1);
`endif

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     lim_q, lim_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic [WIDTH-1:0]     prime_out_q, prime_out_d;
  logic [WIDTH-1:0]     checked_q, checked_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pv_q, pv_d;

  // Verdict datapath. d*d is formed at double width so it cannot overflow.
  // n+step is formed at WIDTH+1 bits so that lim = 2^WIDTH-1 terminates
  // cleanly instead of wrapping.
  logic [2*WIDTH-1:0]   d_ext, n_ext, d_sq;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH:0]       n_next_w;
  logic                 is_prime, is_comp, is_last;

  assign d_ext = {{WIDTH{1'b0}}, d_q};
  assign n_ext = {{WIDTH{1'b0}}, n_q};
  assign d_sq  = d_ext * d_ext;
  assign rem   = n_q % d_q;  // d_q is never 0 in TEST

`ifdef PRIME_SCAN_ODD_SKIP_EN
  // Candidate 2 is accepted directly. The step after 2 is +1; after that it is +2.
  assign is_prime = (n_q == WIDTH'(2)) || (d_sq > n_ext);
  assign n_next_w = {1'b0, n_q} + ((n_q == WIDTH'(2)) ? (WIDTH+1)'(1) : (WIDTH+1)'(2));
`else
  assign is_prime = (d_sq > n_ext);
  assign n_next_w = {1'b0, n_q} + (WIDTH+1)'(1);
`endif

  assign is_comp = !is_prime && (rem == '0);
  assign is_last = n_next_w > {1'b0, lim_q};

  always_comb begin
    state_d     = state_q;
    lim_d       = lim_q;
    n_d         = n_q;
    d_d         = d_q;
    prime_out_d = prime_out_q;
    checked_d   = checked_q;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pv_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          lim_d       = num_max;
          count_d     = '0;
          checked_d   = '0;
          prime_out_d = '0;
          if (num_max < WIDTH'(2)) begin
            state_d = DONE;
          end else begin
            n_d     = WIDTH'(2);
            d_d     = D_INIT;
            busy_d  = 1'b1;
            state_d = TEST;
          end
        end
      end

      TEST: begin
        if (is_prime || is_comp) begin
          checked_d = n_q;
          if (is_prime) begin
            prime_out_d = n_q;
            pv_d        = 1'b1;
            if (!(&count_q)) count_d = count_q + COUNT_W'(1);
          end
          if (is_last) begin
            state_d = DONE;
          end else begin
            n_d = n_next_w[WIDTH-1:0];
            d_d = D_INIT;
          end
        end else begin
          d_d = d_q + D_STEP;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      lim_q       <= '0;
      n_q         <= '0;
      d_q         <= '0;
      prime_out_q <= '0;
      checked_q   <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lim_q       <= lim_d;
      n_q         <= n_d;
      d_q         <= d_d;
      prime_out_q <= prime_out_d;
      checked_q   <= checked_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pv_q        <= pv_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign prime_valid      = pv_q;
  assign prime_out        = prime_out_q;
  assign number_checked   = checked_q;
  assign number_of_primes = count_q;

endmodule

// File: tb/tb_prime_scan_engine.sv
// ---------------------------------------------------------------------------
// tb_prime_scan_engine
//
// Directed testbench for prime_scan_engine with WIDTH=11 and COUNT_W=11.
// Expected values are hand-computed prime facts for each num_max.
// ---------------------------------------------------------------------------
module tb_prime_scan_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] num_max;
  logic        busy;
  logic        done;
  logic        prime_valid;
  logic [10:0] prime_out;
  logic [10:0] number_checked;
  logic [10:0] number_of_primes;

  int checks   = 0;
  int failures = 0;

  // Per-scan observations
  int          cyc;
  int          pulses;
  int          first_pv_cyc;
  bit          timed_out;
  logic [10:0] last_prime;
  logic [10:0] plist [0:7];

  prime_scan_engine #(.WIDTH(11), .COUNT_W(11)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_max          (num_max),
    .busy             (busy),
    .done             (done),
    .prime_valid      (prime_valid),
    .prime_out        (prime_out),
    .number_checked   (number_checked),
    .number_of_primes (number_of_primes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // This task is called #1 after a posedge. The start is accepted at the next edge.
  task automatic issue_start(input logic [10:0] nm, input bit hold);
    start   = 1'b1;
    num_max = nm;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts the edges after the accepted start until done is seen high.
  task automatic wait_done(input int limit);
    cyc          = 0;
    pulses       = 0;
    first_pv_cyc = -1;
    timed_out    = 1'b0;
    last_prime   = '0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (prime_valid === 1'b1) begin
        if (pulses < 8) plist[pulses] = prime_out;
        if (first_pv_cyc < 0) first_pv_cyc = cyc;
        pulses++;
        last_prime = prime_out;
      end
      if (done === 1'b1) break;
      if (cyc >= limit) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    num_max = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_pv",     prime_valid, 0);
    chk("rst_pout",   prime_out, 0);
    chk("rst_nchk",   number_checked, 0);
    chk("rst_nprime", number_of_primes, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // num_max = 10
    issue_start(11'd10, 1'b0);
    chk("s10_busy", busy, 1);
    wait_done(200);
    chk("s10_timeout", timed_out, 0);
    chk("s10_pulses", pulses, 4);
    chk("s10_p0", plist[0], 2);
    chk("s10_p1", plist[1], 3);
    chk("s10_p2", plist[2], 5);
    chk("s10_p3", plist[3], 7);
    chk("s10_first_pv_cyc", first_pv_cyc, 1);
`ifdef PRIME_SCAN_ODD_SKIP_EN
    chk("s10_done_cyc", cyc, 6);
    chk("s10_nchk", number_checked, 9);
`else
    chk("s10_done_cyc", cyc, 13);
    chk("s10_nchk", number_checked, 10);
`endif
    chk("s10_count", number_of_primes, 4);
    chk("s10_busy_at_done", busy, 0);
    // The outputs hold in IDLE after done.
    repeat (3) @(posedge clk);
    #1;
    chk("s10_hold_count", number_of_primes, 4);
    chk("s10_hold_pout", prime_out, 7);
    chk("s10_hold_done", done, 0);
    chk("s10_hold_pv", prime_valid, 0);

    // num_max = 1000
    issue_start(11'd1000, 1'b0);
    wait_done(40000);
    chk("s1000_timeout", timed_out, 0);
    chk("s1000_count", number_of_primes, 168);
    chk("s1000_last", last_prime, 997);
    chk("s1000_pulses", pulses, 168);

    // num_max = 100
    issue_start(11'd100, 1'b0);
    wait_done(5000);
    chk("s100_timeout", timed_out, 0);
    chk("s100_count", number_of_primes, 25);
    chk("s100_last", prime_out, 97);

    // num_max = 0 and 1: immediate done with no pulses
    issue_start(11'd0, 1'b0);
    wait_done(20);
    chk("s0_timeout", timed_out, 0);
    chk("s0_done_fast", (cyc >= 1 && cyc <= 2), 1);
    chk("s0_count", number_of_primes, 0);
    chk("s0_pulses", pulses, 0);
    issue_start(11'd1, 1'b0);
    wait_done(20);
    chk("s1_timeout", timed_out, 0);
    chk("s1_done_fast", (cyc >= 1 && cyc <= 2), 1);
    chk("s1_count", number_of_primes, 0);
    chk("s1_pulses", pulses, 0);

    // num_max = 2
    issue_start(11'd2, 1'b0);
    wait_done(20);
    chk("s2_timeout", timed_out, 0);
    chk("s2_pulses", pulses, 1);
    chk("s2_p0", plist[0], 2);
    chk("s2_count", number_of_primes, 1);
    chk("s2_nchk", number_checked, 2);

    // Reset during the num_max = 500 scan
    issue_start(11'd500, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    chk("mid_busy_before", busy, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy",   busy, 0);
    chk("mid_rst_done",   done, 0);
    chk("mid_rst_pv",     prime_valid, 0);
    chk("mid_rst_pout",   prime_out, 0);
    chk("mid_rst_nchk",   number_checked, 0);
    chk("mid_rst_nprime", number_of_primes, 0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_resume_busy",  busy, 0);
    chk("mid_no_resume_count", number_of_primes, 0);
    issue_start(11'd30, 1'b0);
    wait_done(2000);
    chk("s30_timeout", timed_out, 0);
    chk("s30_count", number_of_primes, 10);
    chk("s30_last", prime_out, 29);

    // start held high for the whole num_max = 20 scan
    issue_start(11'd20, 1'b1);
    wait_done(2000);
    chk("held_timeout", timed_out, 0);
    chk("held_count", number_of_primes, 8);
    chk("held_last", prime_out, 19);
    // The scan has returned to IDLE, so the start that is still held is taken again.
    @(posedge clk);
    #1;
    chk("held_restart_busy", busy, 1);
    chk("held_restart_clear", number_of_primes, 0);
    chk("held_restart_done", done, 0);
    start = 1'b0;
    wait_done(2000);
    chk("held2_timeout", timed_out, 0);
    chk("held2_count", number_of_primes, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
